// File: rtl/shift_right_seq.sv
// Sequential right shifter, one bit per cycle: IDLE -> SHIFT -> DONE. SHIFT_RIGHT_ARITH_EN enables sign-fill via arith.
// Latency shamt+1 cycles from accepted start to done; start is ignored while busy, accepted again in DONE.
module shift_right_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic             mode;
  logic             mode_in;
  logic             accept;
  logic             cnt_zero;
  logic             fill;

`ifdef SHIFT_RIGHT_ARITH_EN
  assign mode_in = arith;
`else
  logic unused_arith;
  assign unused_arith = arith;
  assign mode_in      = 1'b0;
`endif

  assign cnt_zero = (cnt == '0);
  // In arithmetic mode the MSB never changes, so it stays equal to the captured sign bit.
  assign fill     = mode & work[WIDTH-1];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_zero) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      cnt    <= '0;
      mode   <= 1'b0;
      result <= '0;
    end else if (accept) begin
      work <= data_in;
      cnt  <= shamt;
      mode <= mode_in;
    end else if (state == SHIFT) begin
      if (!cnt_zero) begin
        work <= {fill, work[WIDTH-1:1]};
        cnt  <= cnt - 1'b1;
      end else begin
        result <= work;
      end
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: cycle-level reference model plus hand-computed expectations.
module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

`ifdef SHIFT_RIGHT_ARITH_EN
  localparam bit ARITH_EN = 1'b1;
`else
  localparam bit ARITH_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  shift_right_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_shift(input logic [31:0] d, input int sh, input bit a);
    logic [63:0] ext;
    ext = {(a && d[31]) ? 32'hFFFF_FFFF : 32'h0, d};
    ext = ext >> sh;
    return ext[31:0];
  endfunction

  // Reference model: an accepted op at edge N is busy through edge N+shamt, done after edge N+shamt+1.
  int unsigned edge_cnt = 0;
  int unsigned end_edge = 0;
  bit          have_op = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] pend = '0;
  logic [31:0] m_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_op  = 1'b0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_result = '0;
    end else begin
      edge_cnt++;
      if (!m_busy && start) begin
        have_op  = 1'b1;
        end_edge = edge_cnt + 32'(shamt) + 1;
        pend     = model_shift(data_in, int'(shamt), arith && ARITH_EN);
      end
      m_busy = have_op && (edge_cnt < end_edge);
      m_done = have_op && (edge_cnt == end_edge);
      if (have_op && edge_cnt == end_edge) m_result = pend;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("result", result, m_result);
      chk("busy_done_excl", 32'(busy & done), 32'h0);
    end
  end

  task automatic wait_done(input string nm, input int lat0, input int exp_lat, input logic [31:0] exp_res);
    int lat;
    int bcnt;
    lat  = lat0;
    bcnt = lat0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
    chk({nm, "_result"}, result, exp_res);
  endtask

  task automatic run_op(input string nm, input logic [31:0] d, input logic [4:0] sh,
                        input bit a, input logic [31:0] exp_res);
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    shamt   = sh;
    arith   = a;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm, 0, int'(sh) + 1, exp_res);
  endtask

  initial begin
    int dc;
    int lat;

    // Asynchronous reset asserted mid-cycle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("idle_done_count", 32'(dc), 32'h0);

    run_op("logical", 32'h8000_0010, 5'd4, 1'b0, 32'h0800_0001);
    run_op("arith", 32'h8000_0010, 5'd4, 1'b1, ARITH_EN ? 32'hF800_0001 : 32'h0800_0001);
    run_op("shamt0", 32'hDEAD_BEEF, 5'd0, 1'b0, 32'hDEAD_BEEF);
    run_op("shamt31_arith", 32'h8000_0000, 5'd31, 1'b1, ARITH_EN ? 32'hFFFF_FFFF : 32'h0000_0001);
    run_op("shamt31_logic", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);

    // New operands pulsed mid-shift must be ignored
    @(negedge clk);
    start = 1'b1; data_in = 32'h0000_F000; shamt = 5'd12; arith = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("interfere", 4, 13, 32'h0000_000F);

    // Start held high through DONE: second op accepted with no idle cycle
    @(negedge clk);
    start = 1'b1; data_in = 32'h1234_5678; shamt = 5'd3; arith = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_latency", 32'(lat), 32'd4);
    chk("b2b_first_result", result, 32'h0246_8ACF);
    data_in = 32'h0000_0100; shamt = 5'd8;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", 32'(busy), 32'h1);
    wait_done("b2b_second", 0, 9, 32'h0000_0001);

    // Reset two cycles into a long shift, then start on the first edge after release
    @(negedge clk);
    start = 1'b1; data_in = 32'hFFFF_0000; shamt = 5'd20; arith = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", result, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; data_in = 32'h0000_0F00; shamt = 5'd8; arith = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done("after_rst", 0, 9, 32'h0000_000F);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
